// File: rtl/counter_pkg.sv
// Shared definitions for the counter reporter.
// - state_e     : frame FSM states
// - HDR_DEFAULT : default frame header byte
// - frame_len() : bytes in one frame for a given counter width
package counter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_HDR  = 3'd1,
      S_C0   = 3'd2,
      S_C1   = 3'd3,
      S_CSUM = 3'd4
   } state_e;

   localparam logic [7:0] HDR_DEFAULT = 8'hA5;

   // Header + two counters of cnt_w/8 bytes each + checksum byte.
   function automatic int frame_len(input int cnt_w);
      return 2 * (cnt_w / 8) + 2;
   endfunction

endpackage

// File: rtl/counter_reporter.sv
// Captures two counter values on a snap request and streams them as a byte
// frame (HDR, Count0 MSB..LSB, Count1 MSB..LSB, XOR checksum) over a
// valid/ready interface. Snaps that arrive while a frame is busy are counted.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   snap_i       capture-and-send request, one request per high cycle
//   count0_i     counter value 0
//   count1_i     counter value 1
//   tx_data_o    frame byte (registered)
//   tx_valid_o   tx_data_o valid (registered)
//   tx_ready_i   sink accepts the byte when tx_valid_o && tx_ready_i
//   busy_o       frame in progress
//   drop_cnt_o   saturating count of rejected snaps
module counter_reporter
   import counter_pkg::*;
#(
   parameter int         CNT_W = 64,
   parameter logic [7:0] HDR   = HDR_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             snap_i,
   input  logic [CNT_W-1:0] count0_i,
   input  logic [CNT_W-1:0] count1_i,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i,
   output logic             busy_o,
   output logic [7:0]       drop_cnt_o
);

   localparam int N     = CNT_W / 8;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cap0_q, cap0_d;
   logic [CNT_W-1:0] cap1_q, cap1_d;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic [7:0]       drop_q, drop_d;
   logic             accept_s;
   logic             take_snap_s;

   // Byte i of a captured value, counted from the MSB end.
   function automatic logic [7:0] sel_byte(input logic [CNT_W-1:0] v,
                                           input logic [IDX_W-1:0] i);
      return 8'(v >> (8 * (N - 1 - int'(i))));
   endfunction

   assign accept_s = valid_q & tx_ready_i;

   // Next-state logic: the byte for the next position is prepared on accept,
   // so the outputs stay registered and never bubble inside a frame.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cap0_d      = cap0_q;
      cap1_d      = cap1_q;
      csum_d      = csum_q;
      data_d      = data_q;
      valid_d     = valid_q;
      take_snap_s = 1'b0;

      case (state_q)
         IDLE: begin
            if (snap_i) begin
               take_snap_s = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
         S_HDR: begin
            if (accept_s) begin
               state_d = S_C0;
               idx_d   = IDX_ZERO;
               data_d  = sel_byte(cap0_q, IDX_ZERO);
            end else begin
               state_d = S_HDR;
            end
         end
         S_C0: begin
            if (accept_s) begin
               csum_d = csum_q ^ data_q;
               if (idx_q == IDX_LAST) begin
                  state_d = S_C1;
                  idx_d   = IDX_ZERO;
                  data_d  = sel_byte(cap1_q, IDX_ZERO);
               end else begin
                  idx_d  = idx_q + IDX_ONE;
                  data_d = sel_byte(cap0_q, idx_q + IDX_ONE);
               end
            end else begin
               state_d = S_C0;
            end
         end
         S_C1: begin
            if (accept_s) begin
               csum_d = csum_q ^ data_q;
               if (idx_q == IDX_LAST) begin
                  // Checksum byte already includes the byte being accepted now.
                  state_d = S_CSUM;
                  idx_d   = IDX_ZERO;
                  data_d  = csum_q ^ data_q;
               end else begin
                  idx_d  = idx_q + IDX_ONE;
                  data_d = sel_byte(cap1_q, idx_q + IDX_ONE);
               end
            end else begin
               state_d = S_C1;
            end
         end
         S_CSUM: begin
            if (accept_s && snap_i) begin
               take_snap_s = 1'b1;
            end else if (accept_s) begin
               state_d = IDLE;
               valid_d = 1'b0;
               data_d  = 8'h00;
            end else begin
               state_d = S_CSUM;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            data_d  = 8'h00;
         end
      endcase

      if (take_snap_s) begin
         cap0_d  = count0_i;
         cap1_d  = count1_i;
         csum_d  = HDR;
         data_d  = HDR;
         valid_d = 1'b1;
         idx_d   = IDX_ZERO;
         state_d = S_HDR;
      end else begin
         cap0_d = cap0_d;
      end

      if (snap_i && !take_snap_s && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // State and output registers; reset aborts any frame immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= IDX_ZERO;
         cap0_q  <= {CNT_W{1'b0}};
         cap1_q  <= {CNT_W{1'b0}};
         csum_q  <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         drop_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cap0_q  <= cap0_d;
         cap1_q  <= cap1_d;
         csum_q  <= csum_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   assign tx_data_o  = data_q;
   assign tx_valid_o = valid_q;
   assign busy_o     = (state_q != IDLE);
   assign drop_cnt_o = drop_q;

endmodule
